sakebi_eth_fcs_appender: RTL and testbench
==========================================

Name: sakebi_eth_fcs_appender

Overview:
- Upstream controller for sakebi_crc32_calculator.
- Accepts a byte-wide Ethernet frame stream (destination MAC through end of payload) and passes every byte downstream unchanged.
- Drives the calculator one byte per cycle, then appends the 4-byte IEEE 802.3 FCS, so the TX path emits a complete frame.

Parameters:
- DATA_WIDTH, 8, stream byte width; only 8 is supported.
- CRC_WIDTH, 32, CRC register width.
- CRC, 32'h04C11DB7, generator polynomial, forwarded to the calculator.
- CRC_INIT, 32'hFFFFFFFF, XOR mask applied to the first 4 message bytes.
- CRC_XOROUT, 32'hFFFFFFFF, final complement mask.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_data  in  8  upstream byte.
- i_valid  in  1  upstream byte valid.
- i_last  in  1  upstream last payload byte of the frame.
- o_ready  out  1  block can accept an upstream byte.
- o_data  out  8  downstream byte (payload or FCS).
- o_valid  out  1  downstream byte valid.
- o_last  out  1  final byte of the frame on o_data.
- i_ready  in  1  downstream accepts this cycle.
- o_err  out  1  one-cycle pulse: frame shorter than 4 bytes.

Behaviour:
- Handshakes:
  - Upstream transfer when i_valid & o_ready.
  - Downstream transfer when o_valid & i_ready.
  - o_valid, o_data and o_last are held stable until accepted.
- Reset values: o_valid=0, o_data=0, o_last=0, o_ready=0, o_err=0; state=IDLE.
  - Reset mid-frame aborts the frame. No partial FCS is emitted, and the next frame starts fresh.
- Payload path: single output register. o_ready = (state in IDLE/LOAD/BODY) & (!o_valid | i_ready). Latency is 1 cycle, throughput 1 byte/cycle. Payload bytes always leave with o_last=0, except on the short-frame path.
- CRC arithmetic:
  - rev8 and rev32 denote bit reversal.
  - The calculator computes R' = (R*x^8 + B) mod CRC, with {R,B} on its 40-bit input. Its output is registered (1 cycle).
  - LOAD: R = {rev8(b0),rev8(b1),rev8(b2),rev8(b3)} ^ CRC_INIT.
  - BODY: each subsequent byte b is fed as {R, rev8(b)}.
  - FLUSH: 4 zero bytes are fed.
  - FCS = ~rev32(R_final) (i.e. R_final reversed, XOR CRC_XOROUT). Transmit order: FCS[7:0], FCS[15:8], FCS[23:16], FCS[31:24].
- FSM:
  - IDLE: on the first byte handshake, go to LOAD with cnt=1.
  - LOAD: count bytes 1..4.
    - 4th byte with !i_last: go to BODY.
    - 4th byte with i_last: go to FLUSH.
    - i_last on byte 1..3: short frame. That byte is output with o_last=1, o_err pulses in the handshake cycle, no FCS is appended, and the FSM returns to IDLE.
  - BODY: each byte feeds the calculator. On i_last, go to FLUSH.
  - FLUSH: o_ready=0. Lasts exactly 4 cycles of zero-byte feed, then 1 cycle for the calculator register to settle. The FCS is latched into a 32-bit shift register, then go to FCS.
  - FCS: present the 4 bytes in order, advancing only on downstream handshake. o_last=1 on the 4th byte. After it is accepted, go to IDLE.
- Timing: with last-payload handshake at cycle T and no stall, FCS byte 0 is valid at T+6. With downstream stall, it appears once the output register is free and T+6 has passed. The last payload byte always leaves before FCS byte 0.
- Back-to-back frames: after the final FCS handshake, IDLE asserts o_ready the next cycle. No bubble is needed beyond that.
- Upstream stall mid-frame (i_valid=0) freezes the calculator feed; R is held.

Decomposition:
- Package sakebi_eth_pkg holds:
  - constants FCS_BYTES=4, CRC_POLY, CRC_INIT, CRC_XOROUT;
  - the state enum {IDLE, LOAD, BODY, FLUSH, FCS};
  - rev8 and rev32 functions.
- One sub-module instance: sakebi_crc32_calculator, parameterised with DATA_WIDTH, CRC_WIDTH, CRC.
- The R register, init muxing and FCS shifter live in this block.

Test Plan:
- Frame "123456789" (31..39 hex), i_ready=1 → output 31..39, then 26 39 F4 CB. o_last only on CB; FCS byte 0 at T+6.
- Frame 00 00 00 00 → output 00 00 00 00 1C DF 44 21. o_last on 21.
- "123456789" with random i_ready/i_valid deassertion (~50%) → byte sequence identical to case 1, no drops or duplicates, output held stable while stalled.
- 2-byte frame AA BB → output AA, BB with o_last=1 on BB, o_err one-cycle pulse, no FCS. The next frame "123456789" still yields 26 39 F4 CB.
- Two 64-byte random frames back-to-back → each followed by the FCS matching a software CRC-32. o_ready returns high 1 cycle after each final FCS handshake.
- i_rst_n pulsed low during BODY of a frame → all outputs 0 asynchronously. A subsequent "123456789" frame yields correct 26 39 F4 CB.

Source files
------------

// File: rtl/sakebi_eth_pkg.sv
// Shared constants, FSM state type and bit-reversal helpers for the Ethernet FCS appender.
package sakebi_eth_pkg;

    localparam int          FCS_BYTES  = 4;
    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {IDLE, LOAD, BODY, FLUSH, FCS} state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
    endfunction

endpackage

// File: rtl/sakebi_crc32_calculator.sv
// Registered polynomial-division step: o_crc <= ({R,B} as R*x^8 + B) mod CRC, updated when i_en.
module sakebi_crc32_calculator #(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] CRC        = 32'h04C11DB7
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic [CRC_WIDTH+DATA_WIDTH-1:0] i_data,
    output logic [CRC_WIDTH-1:0]            o_crc
);

    logic [CRC_WIDTH-1:0] w_next;

    // Shift the message bits in MSB first, reducing whenever x^CRC_WIDTH appears.
    always_comb begin
        w_next = i_data[CRC_WIDTH+DATA_WIDTH-1 -: CRC_WIDTH];
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (w_next[CRC_WIDTH-1])
                w_next = {w_next[CRC_WIDTH-2:0], i_data[i]} ^ CRC;
            else
                w_next = {w_next[CRC_WIDTH-2:0], i_data[i]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  o_crc <= '0;
        else if (i_en) o_crc <= w_next;
    end

endmodule

// File: rtl/sakebi_eth_fcs_appender.sv
// Byte-stream pass-through that drives the CRC calculator and appends the 4-byte IEEE 802.3 FCS.
module sakebi_eth_fcs_appender
    import sakebi_eth_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          CRC_WIDTH  = 32,
    parameter logic [31:0] CRC        = sakebi_eth_pkg::CRC_POLY,
    parameter logic [31:0] CRC_INIT   = sakebi_eth_pkg::CRC_INIT,
    parameter logic [31:0] CRC_XOROUT = sakebi_eth_pkg::CRC_XOROUT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic                  o_err
);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_load;
    logic        r_sel_load;
    logic [31:0] r_fcs;
    logic        r_alive;

    logic        w_free;
    logic        w_in_payload;
    logic        w_up_hs;
    logic        w_short;
    logic        w_feed;
    logic [7:0]  w_feed_b;
    logic [31:0] w_crc;
    logic [31:0] w_r;
    logic [31:0] w_fcs;

    assign w_free       = !o_valid || i_ready;
    assign w_in_payload = (r_state == IDLE) || (r_state == LOAD) || (r_state == BODY);
    assign o_ready      = r_alive && w_in_payload && w_free;
    assign w_up_hs      = i_valid && o_ready;
    assign w_short      = i_last && ((r_state == IDLE) || ((r_state == LOAD) && (r_cnt < 3'd3)));
    assign o_err        = w_up_hs && w_short;

    // R lives in the calculator register, except right after the 4-byte init load.
    assign w_r      = r_sel_load ? r_load : w_crc;
    assign w_feed   = ((r_state == BODY) && w_up_hs) || ((r_state == FLUSH) && (r_cnt < 3'd4));
    assign w_feed_b = (r_state == FLUSH) ? 8'h00 : rev8(i_data);
    assign w_fcs    = rev32(w_r) ^ CRC_XOROUT;

    sakebi_crc32_calculator #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (CRC_WIDTH),
        .CRC        (CRC)
    ) u_calc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_feed),
        .i_data  ({w_r, w_feed_b}),
        .o_crc   (w_crc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_load     <= '0;
            r_sel_load <= 1'b0;
            r_fcs      <= '0;
            r_alive    <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                IDLE, LOAD, BODY: begin
                    if (w_up_hs) begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                        o_last  <= w_short;
                        r_shift <= {r_shift[15:0], rev8(i_data)};
                        if (r_state == IDLE) begin
                            if (!i_last) begin
                                r_state <= LOAD;
                                r_cnt   <= 3'd1;
                            end
                        end else if (r_state == LOAD) begin
                            if (r_cnt == 3'd3) begin
                                r_load     <= {r_shift, rev8(i_data)} ^ CRC_INIT;
                                r_sel_load <= 1'b1;
                                r_state    <= i_last ? FLUSH : BODY;
                                r_cnt      <= 3'd0;
                            end else if (i_last) begin
                                r_state <= IDLE;
                            end else begin
                                r_cnt <= r_cnt + 3'd1;
                            end
                        end else begin
                            r_sel_load <= 1'b0;
                            if (i_last) begin
                                r_state <= FLUSH;
                                r_cnt   <= 3'd0;
                            end
                        end
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (r_cnt < 3'd4) begin
                        r_cnt      <= r_cnt + 3'd1;
                        r_sel_load <= 1'b0;
                        if (i_ready) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                        end
                    end else begin
                        // Settle cycle: R is final; byte 0 goes out now if the output is free.
                        r_state <= FCS;
                        if (w_free) begin
                            o_data  <= w_fcs[7:0];
                            o_valid <= 1'b1;
                            o_last  <= 1'b0;
                            r_fcs   <= {8'h00, w_fcs[31:8]};
                            r_cnt   <= 3'd1;
                        end else begin
                            r_fcs <= w_fcs;
                            r_cnt <= 3'd0;
                        end
                    end
                end
                FCS: begin
                    if (w_free) begin
                        if (r_cnt == 3'(FCS_BYTES)) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            r_state <= IDLE;
                            r_cnt   <= 3'd0;
                        end else begin
                            o_data  <= r_fcs[7:0];
                            o_valid <= 1'b1;
                            o_last  <= (r_cnt == 3'(FCS_BYTES - 1));
                            r_fcs   <= {8'h00, r_fcs[31:8]};
                            r_cnt   <= r_cnt + 3'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sakebi_eth_fcs_appender.sv
// Scoreboard bench: stimulus pushes expected output bytes, an independent monitor pops and compares.
module tb_sakebi_eth_fcs_appender;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       i_last = 1'b0;
    logic       i_ready = 1'b1;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       o_err;

    sakebi_eth_fcs_appender dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .i_ready (i_ready),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       fcs0;
        logic       fin;
    } exp_t;
    typedef logic [7:0] byte_q_t[$];

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_last = 0;
    int   err_cnt = 0;
    bit   chk_lat = 1'b0;
    bit   rnd_ready = 1'b0;
    bit   rnd_valid = 1'b0;
    bit   chk_rdy = 1'b0;
    bit   hold = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] sw_crc(input byte_q_t fr);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            c ^= {24'h0, fr[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Monitor
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            hold    = 1'b0;
            chk_rdy = 1'b0;
        end else begin
            if (chk_rdy) begin
                chk("ready_after_fcs", {31'h0, o_ready}, 32'h1);
                chk_rdy = 1'b0;
            end
            if (hold) chk("held_output", {22'h0, o_valid, o_last, o_data}, {22'h0, 1'b1, hold_l, hold_d});
            if (o_err) err_cnt++;
            if (i_valid && o_ready && i_last) t_last = cyc;
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    fail($sformatf("unexpected_output data=%h last=%b", o_data, o_last));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_byte{last,data}", {23'h0, o_last, o_data}, {23'h0, e.l, e.d});
                    if (e.fcs0 && chk_lat) chk("fcs0_latency", cyc - t_last, 32'd6);
                    if (e.fin) chk_rdy = 1'b1;
                end
            end
            hold   = o_valid && !i_ready;
            hold_d = o_data;
            hold_l = o_last;
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_ready = rnd_ready ? ($urandom % 2 == 1) : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last, input logic lexp);
        int n = 0;
        bit hs = 1'b0;
        i_data = b;
        i_last = last;
        while (!hs && n < 300) begin
            i_valid = rnd_valid ? ($urandom % 2 == 1) : 1'b1;
            @(negedge i_clk);
            hs = i_valid && o_ready;
            if (hs) q.push_back('{d: b, l: lexp, fcs0: 1'b0, fin: 1'b0});
            @(posedge i_clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (!hs) fail("send_timeout");
    endtask

    task automatic send_frame(input byte_q_t fr, input logic [31:0] fcs, input bit is_short);
        for (int i = 0; i < fr.size(); i++)
            send_byte(fr[i], i == fr.size() - 1, is_short && (i == fr.size() - 1));
        if (!is_short)
            for (int k = 0; k < 4; k++)
                q.push_back('{d: fcs[8*k +: 8], l: (k == 3), fcs0: (k == 0), fin: (k == 3)});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (q.size() != 0) fail("drain_timeout");
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    byte_q_t f123, fz, fs, fa, fb, fr;
    int      e0;

    initial begin
        f123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        fz   = '{8'h00, 8'h00, 8'h00, 8'h00};
        fs   = '{8'hAA, 8'hBB};
        for (int i = 0; i < 64; i++) begin
            fa.push_back(8'($urandom));
            fb.push_back(8'($urandom));
        end
        for (int i = 0; i < 20; i++) fr.push_back(8'(8'h40 + i));

        #2;
        chk("rst_outputs", {27'h0, o_valid, o_last, o_ready, o_err, |o_data}, 32'h0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        chk_lat = 1'b1;
        send_frame(f123, 32'hCBF43926, 1'b0);
        drain();
        send_frame(fz, 32'h2144DF1C, 1'b0);
        drain();

        chk_lat = 1'b0;
        rnd_ready = 1'b1;
        rnd_valid = 1'b1;
        send_frame(f123, 32'hCBF43926, 1'b0);
        drain();
        rnd_ready = 1'b0;
        rnd_valid = 1'b0;
        chk_lat = 1'b1;

        e0 = err_cnt;
        send_frame(fs, 32'h0, 1'b1);
        drain();
        chk("short_err_pulses", err_cnt - e0, 32'd1);
        send_frame(f123, 32'hCBF43926, 1'b0);
        drain();

        send_frame(fa, sw_crc(fa), 1'b0);
        send_frame(fb, sw_crc(fb), 1'b0);
        drain();

        for (int i = 0; i < 8; i++) send_byte(fr[i], 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midframe_rst_outputs", {27'h0, o_valid, o_last, o_ready, o_err, |o_data}, 32'h0);
        q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        send_frame(f123, 32'hCBF43926, 1'b0);
        drain();

        chk("total_err_pulses", err_cnt, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
